branch_predictor: RTL and testbench

- Parametrised dynamic branch prediction unit for the 5-stage MIPS pipeline.
- Replaces the fixed "resolve in ID, flush IF" scheme: a direct-mapped BTB with saturating counters is looked up with the IF-stage PC, and a predicted next PC is supplied to the NPC logic.
- Updated from ID-stage branch/jump resolution; raises a mispredict redirect with the corrected PC.
- Keeps saturating performance counters.

---
 rtl/bp_pkg.sv | 37 +++
 rtl/bp_sat_counter.sv | 19 +
 rtl/branch_predictor.sv | 115 +++++++++++
 tb/tb_branch_predictor.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: counter encodings and
// width helpers used by the BTB and its saturating-counter update logic.
package bp_pkg;

  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,
    CNT_WNT = 2'b01,
    CNT_WT  = 2'b10,
    CNT_ST  = 2'b11
  } cnt2_e;

  localparam int PC_W = 32;

  function automatic int idx_w(input int entries);
    return (entries <= 2) ? 1 : $clog2(entries);
  endfunction

  // Word-aligned PC bits left over once the index has been taken out.
  function automatic int tag_w(input int entries);
    return PC_W - 2 - idx_w(entries);
  endfunction

  // MSB set, all others clear; returned zero-extended to 8 bits.
  function automatic logic [7:0] cnt_weak_taken(input int cnt_w);
    logic [7:0] v;
    v = 8'd1 << (cnt_w - 1);
    return v;
  endfunction

  // MSB clear, all others set; collapses to 0 for a 1-bit counter.
  function automatic logic [7:0] cnt_weak_not_taken(input int cnt_w);
    logic [7:0] v;
    v = (8'd1 << (cnt_w - 1)) - 8'd1;
    return v;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Next-value logic for a CNT_W-wide saturating up/down prediction counter.
module bp_sat_counter #(
  parameter int CNT_W = 2
) (
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             up_i,
  output logic [CNT_W-1:0] cnt_o
);

  always_comb begin
    cnt_o = cnt_i;
    if (up_i) begin
      if (cnt_i != '1) cnt_o = cnt_i + 1'b1;
    end else begin
      if (cnt_i != '0) cnt_o = cnt_i - 1'b1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating counters: IF-stage lookup, ID-stage
// update, mispredict redirect and saturating performance counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  parameter int MODE    = 1,
  parameter int PERF_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       if_pc,
  output logic              pred_taken,
  output logic [31:0]       pred_target,
  input  logic              upd_valid,
  input  logic              upd_stall,
  input  logic [31:0]       upd_pc,
  input  logic              upd_taken,
  input  logic [31:0]       upd_target,
  input  logic              upd_pred_taken,
  input  logic [31:0]       upd_pred_target,
  output logic              mispredict,
  output logic [31:0]       redirect_pc,
  output logic [PERF_W-1:0] perf_lookups,
  output logic [PERF_W-1:0] perf_mispredicts
);

  localparam int         IDX_W = idx_w(ENTRIES);
  localparam int         TAG_W = tag_w(ENTRIES);
  localparam bit         DYN   = (MODE != 0);
  localparam logic [7:0] WT8   = cnt_weak_taken(CNT_W);
  localparam logic [7:0] WNT8  = cnt_weak_not_taken(CNT_W);
  localparam logic [CNT_W-1:0] CNT_WT_V  = WT8[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_WNT_V = WNT8[CNT_W-1:0];

  logic             valid_q [ENTRIES];
  logic [CNT_W-1:0] cnt_q   [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [29:0]      tgt_q   [ENTRIES];

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             lk_hit, upd_hit, upd_en, wr_en;
  logic [CNT_W-1:0] cnt_d;
  logic [PERF_W-1:0] perf_lk_q, perf_lk_d, perf_mp_q, perf_mp_d;

  assign lk_idx  = if_pc[IDX_W+1:2];
  assign lk_tag  = if_pc[31:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[31:IDX_W+2];

  // Lookup reads registered state only, so a same-cycle update is not bypassed.
  assign lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken  = DYN && lk_hit && cnt_q[lk_idx][CNT_W-1];
  assign pred_target = pred_taken ? {tgt_q[lk_idx], 2'b00} : if_pc + 32'd4;

  assign upd_en      = upd_valid && !upd_stall;
  assign wr_en       = DYN && upd_en;
  assign upd_hit     = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign mispredict  = upd_en && ((upd_taken != upd_pred_taken) ||
                                  (upd_taken && (upd_target != upd_pred_target)));
  assign redirect_pc = upd_taken ? upd_target : upd_pc + 32'd4;

  bp_sat_counter #(.CNT_W(CNT_W)) u_sat (
    .cnt_i (cnt_q[upd_idx]),
    .up_i  (upd_taken),
    .cnt_o (cnt_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= CNT_WNT_V;
      end
    end else if (wr_en) begin
      if (upd_hit) begin
        cnt_q[upd_idx] <= cnt_d;
      end else if (upd_taken) begin
        valid_q[upd_idx] <= 1'b1;
        cnt_q[upd_idx]   <= CNT_WT_V;
      end
    end
  end

  // Tag/target need no reset: they are meaningless while valid is clear.
  always_ff @(posedge clk) begin
    if (wr_en && upd_taken) begin
      tag_q[upd_idx] <= upd_tag;
      tgt_q[upd_idx] <= upd_target[31:2];
    end
  end

  always_comb begin
    perf_lk_d = perf_lk_q;
    perf_mp_d = perf_mp_q;
    if (upd_en && (perf_lk_q != '1)) perf_lk_d = perf_lk_q + PERF_W'(1);
    if (mispredict && (perf_mp_q != '1)) perf_mp_d = perf_mp_q + PERF_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_lk_q <= '0;
      perf_mp_q <= '0;
    end else begin
      perf_lk_q <= perf_lk_d;
      perf_mp_q <= perf_mp_d;
    end
  end

  assign perf_lookups     = perf_lk_q;
  assign perf_mispredicts = perf_mp_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: table-driven vectors with a scoreboard queue on a
// dynamic instance, plus a MODE=0 / PERF_W=4 instance and an async-reset sequence.
module tb_branch_predictor;
  import bp_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] if_pc, upd_pc, upd_target, upd_pred_target;
  logic        upd_valid, upd_stall, upd_taken, upd_pred_taken;
  logic        pred_taken, mispredict;
  logic [31:0] pred_target, redirect_pc, perf_lookups, perf_mispredicts;

  logic [31:0] z_if_pc, z_upd_pc, z_upd_target, z_upd_pred_target;
  logic        z_upd_valid, z_upd_stall, z_upd_taken, z_upd_pred_taken;
  logic        z_pred_taken, z_mispredict;
  logic [31:0] z_pred_target, z_redirect_pc;
  logic [3:0]  z_perf_lookups, z_perf_mispredicts;

  branch_predictor #(.ENTRIES(16), .CNT_W(2), .MODE(1), .PERF_W(32)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_stall(upd_stall), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .perf_lookups(perf_lookups), .perf_mispredicts(perf_mispredicts)
  );

  branch_predictor #(.ENTRIES(16), .CNT_W(2), .MODE(0), .PERF_W(4)) dut_m0 (
    .clk(clk), .rst(rst), .if_pc(z_if_pc), .pred_taken(z_pred_taken), .pred_target(z_pred_target),
    .upd_valid(z_upd_valid), .upd_stall(z_upd_stall), .upd_pc(z_upd_pc), .upd_taken(z_upd_taken),
    .upd_target(z_upd_target), .upd_pred_taken(z_upd_pred_taken),
    .upd_pred_target(z_upd_pred_target), .mispredict(z_mispredict), .redirect_pc(z_redirect_pc),
    .perf_lookups(z_perf_lookups), .perf_mispredicts(z_perf_mispredicts)
  );

  typedef struct {
    logic uv, us; logic [31:0] upc; logic ut; logic [31:0] utgt;
    logic upt; logic [31:0] uptgt; logic [31:0] ifpc;
    logic ept; logic [31:0] etgt; logic emp; logic [31:0] erd;
  } vec_t;

  typedef struct {
    int id; logic pt; logic [31:0] tgt; logic mp; logic [31:0] rd;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t v(logic uv, logic us, logic [31:0] upc, logic ut, logic [31:0] utgt,
                             logic upt, logic [31:0] uptgt, logic [31:0] ifpc,
                             logic ept, logic [31:0] etgt, logic emp, logic [31:0] erd);
    vec_t r;
    r.uv = uv; r.us = us; r.upc = upc; r.ut = ut; r.utgt = utgt; r.upt = upt;
    r.uptgt = uptgt; r.ifpc = ifpc; r.ept = ept; r.etgt = etgt; r.emp = emp; r.erd = erd;
    return r;
  endfunction

  function automatic vec_t idle(logic [31:0] ifpc, logic ept, logic [31:0] etgt);
    return v(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, ifpc, ept, etgt, 1'b0, 32'h4);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    upd_valid = 1'b0; upd_stall = 1'b0; upd_pc = 32'h0; upd_taken = 1'b0;
    upd_target = 32'h0; upd_pred_taken = 1'b0; upd_pred_target = 32'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_lk, exp_mp;
    exp_t e;
    rst = 1'b1;
    if_pc = 32'h3000;
    drive_idle();
    z_if_pc = 32'h3010; z_upd_valid = 1'b0; z_upd_stall = 1'b0; z_upd_pc = 32'h0;
    z_upd_taken = 1'b0; z_upd_target = 32'h0; z_upd_pred_taken = 1'b0; z_upd_pred_target = 32'h0;

    vecs.push_back(idle(32'h3000, 1'b0, 32'h3004));
    vecs.push_back(v(1,0,32'h3010,1,32'h3040,0,32'h3014, 32'h3010,0,32'h3014,1,32'h3040));
    vecs.push_back(idle(32'h3010, 1'b1, 32'h3040));
    for (int k = 0; k < 4; k++)
      vecs.push_back(v(1,0,32'h3010,1,32'h3040,1,32'h3040, 32'h3010,1,32'h3040,0,32'h3040));
    vecs.push_back(v(1,0,32'h3010,0,32'h3040,1,32'h3040, 32'h3010,1,32'h3040,1,32'h3014));
    vecs.push_back(v(1,0,32'h3010,0,32'h3040,1,32'h3040, 32'h3010,1,32'h3040,1,32'h3014));
    vecs.push_back(idle(32'h3010, 1'b0, 32'h3014));
    vecs.push_back(v(1,0,32'h3010,0,32'h3040,0,32'h3014, 32'h3010,0,32'h3014,0,32'h3014));
    vecs.push_back(v(1,0,32'h3010,1,32'h3040,1,32'h3080, 32'h3010,0,32'h3014,1,32'h3040));
    vecs.push_back(v(1,0,32'h3010,1,32'h3040,0,32'h3014, 32'h3010,0,32'h3014,1,32'h3040));
    vecs.push_back(idle(32'h3010, 1'b1, 32'h3040));
    vecs.push_back(v(1,0,32'h3050,1,32'h3100,0,32'h3054, 32'h3010,1,32'h3040,1,32'h3100));
    vecs.push_back(idle(32'h3010, 1'b0, 32'h3014));
    vecs.push_back(idle(32'h3050, 1'b1, 32'h3100));
    vecs.push_back(v(1,0,32'h3050,1,32'h3200,1,32'h3100, 32'h3050,1,32'h3100,1,32'h3200));
    vecs.push_back(idle(32'h3050, 1'b1, 32'h3200));
    vecs.push_back(v(1,1,32'h3020,1,32'h3300,0,32'h3024, 32'h3050,1,32'h3200,0,32'h3300));
    vecs.push_back(idle(32'h3020, 1'b0, 32'h3024));
    vecs.push_back(v(1,0,32'h3024,0,32'h0,0,32'h3028, 32'h3024,0,32'h3028,0,32'h3028));
    vecs.push_back(idle(32'h3024, 1'b0, 32'h3028));
    vecs.push_back(v(1,1,32'h3050,0,32'h0,1,32'h3200, 32'h3050,1,32'h3200,0,32'h3054));
    vecs.push_back(idle(32'h3050, 1'b1, 32'h3200));

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_perf_lookups", perf_lookups, 32'h0);
    chk("reset_perf_mispredicts", perf_mispredicts, 32'h0);
    chk("reset_mispredict", {31'h0, mispredict}, 32'h0);

    exp_lk = 0; exp_mp = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      upd_valid = vecs[i].uv; upd_stall = vecs[i].us; upd_pc = vecs[i].upc;
      upd_taken = vecs[i].ut; upd_target = vecs[i].utgt; upd_pred_taken = vecs[i].upt;
      upd_pred_target = vecs[i].uptgt; if_pc = vecs[i].ifpc;
      e.id = i; e.pt = vecs[i].ept; e.tgt = vecs[i].etgt; e.mp = vecs[i].emp; e.rd = vecs[i].erd;
      sb.push_back(e);
      if (vecs[i].uv && !vecs[i].us) exp_lk++;
      if (vecs[i].emp) exp_mp++;
      @(negedge clk);
      if (sb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL scoreboard_empty: got 0 entries, want 1");
      end else begin
        e = sb.pop_front();
        chk($sformatf("v%0d_pred_taken", e.id), {31'h0, pred_taken}, {31'h0, e.pt});
        chk($sformatf("v%0d_pred_target", e.id), pred_target, e.tgt);
        chk($sformatf("v%0d_mispredict", e.id), {31'h0, mispredict}, {31'h0, e.mp});
        chk($sformatf("v%0d_redirect_pc", e.id), redirect_pc, e.rd);
      end
    end

    @(posedge clk);
    #1 drive_idle();
    if_pc = 32'h3050;
    @(negedge clk);
    chk("perf_lookups", perf_lookups, exp_lk);
    chk("perf_mispredicts", perf_mispredicts, exp_mp);
    chk("pre_rst_pred_taken", {31'h0, pred_taken}, 32'h1);

    // Asynchronous reset between edges must clear the table at once.
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_pred_taken", {31'h0, pred_taken}, 32'h0);
    chk("async_rst_pred_target", pred_target, 32'h3054);
    chk("async_rst_perf_lookups", perf_lookups, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_pred_taken", {31'h0, pred_taken}, 32'h0);

    // MODE=0 instance: counters move, table never written, 4-bit perf saturates.
    for (int i = 0; i < 17; i++) begin
      @(posedge clk);
      #1;
      z_upd_valid = 1'b1; z_upd_pc = 32'h3010; z_upd_taken = 1'b1;
      z_upd_target = 32'h3040; z_upd_pred_taken = 1'b0; z_upd_pred_target = 32'h3014;
      z_if_pc = 32'h3010;
      @(negedge clk);
      chk($sformatf("m0_%0d_pred_taken", i), {31'h0, z_pred_taken}, 32'h0);
      chk($sformatf("m0_%0d_mispredict", i), {31'h0, z_mispredict}, 32'h1);
      if (i == 14) chk("m0_perf_mis_14", {28'h0, z_perf_mispredicts}, 32'd14);
    end
    @(posedge clk);
    #1 z_upd_valid = 1'b0;
    @(negedge clk);
    chk("m0_perf_lookups_sat", {28'h0, z_perf_lookups}, 32'd15);
    chk("m0_perf_mispredicts_sat", {28'h0, z_perf_mispredicts}, 32'd15);
    chk("m0_pred_target", z_pred_target, 32'h3014);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
